wb_port_decoder: RTL and testbench
==================================

Name: wb_port_decoder

Overview:
- Multi-port write-back decoder for the register bank.
- Each write port presents a register select. The block resolves same-register conflicts between ports and drives registered one-hot write enables.
- An anti-starvation boost gives a repeatedly stalled port top priority.
- It replaces the single-port combinational select decoder. It sits between the write-back stage and the register array.

Parameters:
- SEL_W, 5, register select width; the bank has NREG = 2**SEL_W registers.
- NUM_PORTS, 2, number of write ports (1..4).
- ZERO_REG, 1, if 1, register 0 is hardwired zero: writes to it are accepted and discarded.
- MAX_STALL, 3, consecutive stalled cycles after which a port is boosted (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port write request valid.
- req_sel  in  NUM_PORTS*SEL_W  per-port register select; port i occupies bits [i*SEL_W +: SEL_W].
- req_ready  out  NUM_PORTS  per-port accept, combinational.
- we_out  out  NUM_PORTS*NREG  registered per-port one-hot enables; port i occupies bits [i*NREG +: NREG].
- we_any  out  NREG  registered OR of all ports' enables.
- boost_active  out  NUM_PORTS  registered; port is currently boosted.
- conflict_cnt  out  16  registered count of stall events.

Behaviour:
- Reset (rst_n low, asynchronous): we_out, we_any, boost_active, conflict_cnt and all stall counters go to 0. req_ready is 0 while rst_n is low.
- Handshake: a request is accepted when req_valid[i] && req_ready[i] at a rising edge. A stalled port must hold req_valid and req_sel stable until accepted. The block does not check this.
- Priority:
  - Effective order is boosted ports first, in ascending index, then non-boosted ports, in ascending index.
  - A port is boosted when its stall count equals MAX_STALL.
- req_ready[i] = 1 unless some higher-effective-priority port j has req_valid[j] && req_sel[j] == req_sel[i] && !(ZERO_REG && req_sel[i] == 0).
  - req_ready is independent of req_valid[i] itself.
  - Selects to register 0 with ZERO_REG=1 never conflict and are always ready.
- Decode: on acceptance at edge t, we_out bit (i*NREG + req_sel[i]) is 1 for exactly the cycle after edge t, i.e. 1-cycle latency. It is 0 otherwise.
  - Accepted sel 0 with ZERO_REG=1 produces no enable.
  - With ZERO_REG=0, register 0 decodes normally.
- we_any is the bitwise OR of the per-port enables, registered on the same edge. At most one port sets any given bit.
- Stall counter per port, width 4:
  - Increments (saturating at MAX_STALL) on each edge where req_valid[i] && !req_ready[i].
  - Clears to 0 on acceptance.
  - Holds when req_valid[i] = 0.
  - boost_active[i] = (count == MAX_STALL).
- conflict_cnt adds the number of stalled ports (valid && !ready) each edge. It saturates at 16'hFFFF and never wraps.
- Simultaneous boosts: several boosted ports with the same select resolve by ascending index. The losers keep counting, already saturated, and remain boosted.
- NUM_PORTS = 1: req_ready is always 1 out of reset, and the counters never move.
- Reset mid-operation: pending stalls and boosts are discarded. Enables issued on the edge before reset are cleared asynchronously.

Test Plan:
- Single write: port0 valid, sel=5 -> req_ready=1; next cycle we_out[5]=1, we_any=32'h0000_0020; following cycle both 0.
- Conflict: ports 0 and 1 both sel=7, held for 1 cycle -> port1 ready=0; we_out[7]=1 for port0 only; port1 accepted the next cycle, we_out[32+7]=1; conflict_cnt=1.
- Starvation boost (MAX_STALL=3): port0 issues a new sel=9 write every cycle; port1 holds sel=9.
  - port1 stalls 3 cycles, then boost_active[1]=1.
  - Next cycle port1 ready=1 and port0 ready=0.
  - port1's counter clears after acceptance; conflict_cnt=4.
- Zero register: ZERO_REG=1, both ports sel=0 -> both ready=1, we_out all 0, conflict_cnt unchanged. With ZERO_REG=0 -> port1 stalls and we_any[0]=1.
- Distinct selects: port0 sel=3, port1 sel=31 in the same cycle -> both accepted, we_any=32'h8000_0008.
- Async reset: assert rst_n low mid-cycle while we_out is nonzero and port1 is boosted -> all outputs 0 immediately; after release, port1 stall count is 0 and boost_active=0.

Source files
------------

// File: rtl/wb_port_decoder_if.sv
// Write-back decoder bus: per-port register-select requests in, registered
// one-hot write enables and status out.
interface wb_port_decoder_if #(
  parameter int SEL_W     = 5,
  parameter int NUM_PORTS = 2
);
  localparam int NREG = 2 ** SEL_W;

  // Handshake: port i is accepted at a rising edge where req_valid[i] && req_ready[i].
  // A stalled port keeps req_valid[i] and its req_sel slice stable until accepted.
  logic [NUM_PORTS-1:0]       req_valid;
  logic [NUM_PORTS*SEL_W-1:0] req_sel;
  logic [NUM_PORTS-1:0]       req_ready;
  logic [NUM_PORTS*NREG-1:0]  we_out;
  logic [NREG-1:0]            we_any;
  logic [NUM_PORTS-1:0]       boost_active;
  logic [15:0]                conflict_cnt;

  modport master (
    output req_valid, req_sel,
    input  req_ready, we_out, we_any, boost_active, conflict_cnt
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, we_out, we_any, boost_active, conflict_cnt
  );
endinterface

// File: rtl/wb_port_decoder.sv
// Multi-port write-back decoder: resolves same-register conflicts between write
// ports, boosts starved ports and drives registered one-hot write enables.
module wb_port_decoder #(
  parameter int SEL_W     = 5,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_REG  = 1,
  parameter int MAX_STALL = 3
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_decoder_if.slave  bus
);
  localparam int NREG = 2 ** SEL_W;

  logic [3:0]                stall_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]      boost;
  logic [NUM_PORTS-1:0]      ready;
  logic [NUM_PORTS-1:0]      stalled;
  logic [NUM_PORTS-1:0]      accept;
  logic [NUM_PORTS*NREG-1:0] we_d;
  logic [NREG-1:0]           any_d;
  logic [16:0]               cnt_sum;

  function automatic logic [SEL_W-1:0] sel_of(input logic [NUM_PORTS*SEL_W-1:0] v, input int p);
    return v[p*SEL_W +: SEL_W];
  endfunction

  function automatic logic is_zero(input logic [SEL_W-1:0] s);
    return (ZERO_REG != 0) && (s == '0);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      boost[i] = (stall_q[i] == 4'(MAX_STALL));
    end
  end

  // Port j outranks port i when boosted over non-boosted, else by lower index.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ready[i] = rst_n;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j != i) begin
          if (((boost[j] && !boost[i]) || ((boost[j] == boost[i]) && (j < i))) &&
              bus.req_valid[j] && (sel_of(bus.req_sel, j) == sel_of(bus.req_sel, i)) &&
              !is_zero(sel_of(bus.req_sel, i))) begin
            ready[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    accept  = bus.req_valid & ready;
    stalled = bus.req_valid & ~ready;
    we_d    = '0;
    any_d   = '0;
    cnt_sum = {1'b0, bus.conflict_cnt};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (accept[i] && !is_zero(sel_of(bus.req_sel, i))) begin
        we_d[i*NREG + int'(sel_of(bus.req_sel, i))] = 1'b1;
      end
      any_d   = any_d | we_d[i*NREG +: NREG];
      cnt_sum = cnt_sum + {16'd0, stalled[i]};
    end
  end

  assign bus.req_ready    = ready;
  assign bus.boost_active = boost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we_out       <= '0;
      bus.we_any       <= '0;
      bus.conflict_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        stall_q[i] <= '0;
      end
    end else begin
      bus.we_out       <= we_d;
      bus.we_any       <= any_d;
      bus.conflict_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) begin
          stall_q[i] <= '0;
        end else if (stalled[i] && (stall_q[i] != 4'(MAX_STALL))) begin
          stall_q[i] <= stall_q[i] + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_port_decoder.sv
// Directed vector bench for wb_port_decoder: a two-port ZERO_REG=1 main
// instance, a ZERO_REG=0 twin and a single-port instance on shared stimulus.
module tb_wb_port_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_port_decoder_if #(.SEL_W(5), .NUM_PORTS(2)) bus ();
  wb_port_decoder_if #(.SEL_W(5), .NUM_PORTS(2)) bus_z0 ();
  wb_port_decoder_if #(.SEL_W(5), .NUM_PORTS(1)) bus_1p ();

  assign bus_z0.req_valid = bus.req_valid;
  assign bus_z0.req_sel   = bus.req_sel;
  assign bus_1p.req_valid = bus.req_valid[0];
  assign bus_1p.req_sel   = bus.req_sel[4:0];

  wb_port_decoder #(.SEL_W(5), .NUM_PORTS(2), .ZERO_REG(1), .MAX_STALL(3))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  wb_port_decoder #(.SEL_W(5), .NUM_PORTS(2), .ZERO_REG(0), .MAX_STALL(3))
    dut_z0 (.clk(clk), .rst_n(rst_n), .bus(bus_z0.slave));
  wb_port_decoder #(.SEL_W(5), .NUM_PORTS(1), .ZERO_REG(1), .MAX_STALL(3))
    dut_1p (.clk(clk), .rst_n(rst_n), .bus(bus_1p.slave));

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [1:0]  rdy;
    logic [31:0] we0;
    logic [31:0] we1;
    logic [1:0]  bst;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    bus.req_valid = t.v;
    bus.req_sel   = {t.s1, t.s0};
    #1;
    chk({tag, " ready"}, 64'(bus.req_ready), 64'(t.rdy));
    chk({tag, " ready_1p"}, 64'(bus_1p.req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, " we_out"}, bus.we_out, {t.we1, t.we0});
    chk({tag, " we_any"}, 64'(bus.we_any), 64'(t.we0 | t.we1));
    chk({tag, " boost"}, 64'(bus.boost_active), 64'(t.bst));
    chk({tag, " conflict_cnt"}, 64'(bus.conflict_cnt), 64'(t.cnt));
  endtask

  initial begin
    // single write, idle, conflict, distinct selects, register 0
    tbl[0]  = '{2'b01, 5'd5,  5'd0,  2'b11, 32'h0000_0020, 32'h0,          2'b00, 16'd0};
    tbl[1]  = '{2'b00, 5'd5,  5'd0,  2'b11, 32'h0,          32'h0,          2'b00, 16'd0};
    tbl[2]  = '{2'b11, 5'd7,  5'd7,  2'b01, 32'h0000_0080, 32'h0,          2'b00, 16'd1};
    tbl[3]  = '{2'b10, 5'd7,  5'd7,  2'b11, 32'h0,          32'h0000_0080, 2'b00, 16'd1};
    tbl[4]  = '{2'b11, 5'd3,  5'd31, 2'b11, 32'h0000_0008, 32'h8000_0000, 2'b00, 16'd1};
    tbl[5]  = '{2'b11, 5'd0,  5'd0,  2'b11, 32'h0,          32'h0,          2'b00, 16'd1};
    // starvation: port1 stalls three times, is boosted, then wins
    tbl[6]  = '{2'b11, 5'd9,  5'd9,  2'b01, 32'h0000_0200, 32'h0,          2'b00, 16'd2};
    tbl[7]  = '{2'b11, 5'd9,  5'd9,  2'b01, 32'h0000_0200, 32'h0,          2'b00, 16'd3};
    tbl[8]  = '{2'b11, 5'd9,  5'd9,  2'b01, 32'h0000_0200, 32'h0,          2'b10, 16'd4};
    tbl[9]  = '{2'b11, 5'd9,  5'd9,  2'b10, 32'h0,          32'h0000_0200, 2'b00, 16'd5};
    tbl[10] = '{2'b00, 5'd9,  5'd9,  2'b11, 32'h0,          32'h0,          2'b00, 16'd5};
    // rebuild a boost on port1 ahead of the reset test
    tbl[11] = '{2'b11, 5'd12, 5'd12, 2'b01, 32'h0000_1000, 32'h0,          2'b00, 16'd6};
    tbl[12] = '{2'b11, 5'd12, 5'd12, 2'b01, 32'h0000_1000, 32'h0,          2'b00, 16'd7};
    tbl[13] = '{2'b11, 5'd12, 5'd12, 2'b01, 32'h0000_1000, 32'h0,          2'b10, 16'd8};

    bus.req_valid = '0;
    bus.req_sel   = '0;
    #3;
    chk("reset we_out", bus.we_out, 64'd0);
    chk("reset we_any", 64'(bus.we_any), 64'd0);
    chk("reset boost", 64'(bus.boost_active), 64'd0);
    chk("reset conflict_cnt", 64'(bus.conflict_cnt), 64'd0);
    chk("reset ready", 64'(bus.req_ready), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 14; k++) begin
      apply(tbl[k], $sformatf("vec%0d", k));
    end

    // async reset while port0 enable is live and port1 is boosted
    #2 rst_n = 1'b0;
    #1;
    chk("async we_out", bus.we_out, 64'd0);
    chk("async we_any", 64'(bus.we_any), 64'd0);
    chk("async boost", 64'(bus.boost_active), 64'd0);
    chk("async conflict_cnt", 64'(bus.conflict_cnt), 64'd0);
    chk("async ready", 64'(bus.req_ready), 64'd0);
    chk("async ready_1p", 64'(bus_1p.req_ready), 64'd0);
    bus.req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset boost", 64'(bus.boost_active), 64'd0);
    // port1 stall count restarted at 0, so port0 wins by index again
    apply('{2'b11, 5'd12, 5'd12, 2'b01, 32'h0000_1000, 32'h0, 2'b00, 16'd1}, "post-reset");

    // register 0: discarded and conflict-free with ZERO_REG=1, normal with ZERO_REG=0
    bus.req_valid = 2'b11;
    bus.req_sel   = {5'd0, 5'd0};
    #1;
    chk("zero ready", 64'(bus.req_ready), 64'b11);
    chk("zero0 ready", 64'(bus_z0.req_ready), 64'b01);
    @(posedge clk);
    #1;
    chk("zero we_out", bus.we_out, 64'd0);
    chk("zero conflict_cnt", 64'(bus.conflict_cnt), 64'd1);
    chk("zero0 we_out", bus_z0.we_out, 64'h0000_0000_0000_0001);
    chk("zero0 we_any", 64'(bus_z0.we_any), 64'h1);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    chk("idle we_any", 64'(bus.we_any), 64'd0);
    chk("1p boost", 64'(bus_1p.boost_active), 64'd0);
    chk("1p conflict_cnt", 64'(bus_1p.conflict_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
